// File: rtl/motor_ramp_sequencer.sv
// Drive-motor sequencer: debounces the operator switches, ramps PWM duty at period
// boundaries and enforces brake plus dead time before any change of direction.
module motor_ramp_sequencer #(
  parameter int PERIOD       = 1000000,
  parameter int DUTY_SLOW    = 200000,
  parameter int DUTY_FAST    = 900000,
  parameter int RAMP_STEP    = 10000,
  parameter int DEAD_PERIODS = 50,
  parameter int DEBOUNCE_CYC = 100000,
  localparam int DW          = $clog2(PERIOD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_run,
  input  logic          cmd_dir,
  input  logic          cmd_fast,
  output logic [2:0]    motor_r,
  output logic [2:0]    motor_l,
  output logic [DW-1:0] duty,
  output logic [1:0]    state,
  output logic          busy
);

  localparam int SW = $clog2(DEBOUNCE_CYC + 1);
  localparam int XW = $clog2(DEAD_PERIODS + 1);

  localparam logic [DW-1:0] ZERO_D   = {DW{1'b0}};
  localparam logic [DW-1:0] ONE_D    = DW'(1);
  localparam logic [DW-1:0] PB_CNT   = DW'(PERIOD - 1);
  localparam logic [DW-1:0] STEP_W   = DW'(RAMP_STEP);
  localparam logic [DW-1:0] SLOW_W   = DW'(DUTY_SLOW);
  localparam logic [DW-1:0] FAST_W   = DW'(DUTY_FAST);
  localparam logic [SW-1:0] DEB_LAST = SW'(DEBOUNCE_CYC - 1);
  localparam logic [SW-1:0] DEB_MAX  = SW'(DEBOUNCE_CYC);
  localparam logic [SW-1:0] STAB_ONE = SW'(1);
  localparam logic [XW-1:0] DEAD_LD  = XW'(DEAD_PERIODS);
  localparam logic [XW-1:0] DEAD_ONE = XW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_BRAKE = 2'b10,
    ST_DEAD  = 2'b11
  } state_e;

  // Move one step toward tgt, landing exactly on it instead of overshooting.
  function automatic logic [DW-1:0] ramp_toward(input logic [DW-1:0] cur, input logic [DW-1:0] tgt);
    logic [DW-1:0] r;
    if (cur < tgt) begin
      if ((tgt - cur) > STEP_W) r = cur + STEP_W;
      else                      r = tgt;
    end else if (cur > tgt) begin
      if ((cur - tgt) > STEP_W) r = cur - STEP_W;
      else                      r = tgt;
    end else begin
      r = cur;
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] step_down(input logic [DW-1:0] cur);
    logic [DW-1:0] r;
    if (cur > STEP_W) r = cur - STEP_W;
    else              r = ZERO_D;
    return r;
  endfunction

  logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [DW-1:0] cnt_q, cnt_d, duty_q, duty_d, tgt;
  logic [XW-1:0] dead_cnt_q, dead_cnt_d;
  state_e        state_q, state_d;
  logic          dir_lat_q, dir_lat_d, pwm_q, pwm_d, busy_q, busy_d;
  logic [1:0]    dir_out_q, dir_out_d;
  logic          run_db, dir_db, fast_db, pb;

  // Synchronizer and stability filter; a change entering sync2 restarts the count.
  always_comb begin
    sync1_d = {cmd_run, cmd_dir, cmd_fast};
    sync2_d = sync1_q;
    if (sync1_q != sync2_q) begin
      stab_d = {SW{1'b0}};
    end else if (stab_q != DEB_MAX) begin
      stab_d = stab_q + STAB_ONE;
    end else begin
      stab_d = stab_q;
    end
    if ((sync1_q == sync2_q) && (stab_q == DEB_LAST)) begin
      db_d = sync2_q;
    end else begin
      db_d = db_q;
    end
  end

  // Sequencer next state, duty ramp and registered pin values.
  always_comb begin
    run_db     = db_q[2];
    dir_db     = db_q[1];
    fast_db    = db_q[0];
    pb         = (cnt_q == PB_CNT);
    tgt        = run_db ? (fast_db ? FAST_W : SLOW_W) : ZERO_D;
    cnt_d      = pb ? ZERO_D : (cnt_q + ONE_D);
    state_d    = state_q;
    duty_d     = duty_q;
    dir_lat_d  = dir_lat_q;
    dead_cnt_d = dead_cnt_q;
    case (state_q)
      ST_IDLE: begin
        duty_d = ZERO_D;
        if (run_db) begin
          dir_lat_d = dir_db;
          state_d   = ST_DRIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        // Brake entry is immediate; a coinciding boundary already applies the first brake step.
        if (!run_db || (dir_db != dir_lat_q)) begin
          state_d = ST_BRAKE;
          duty_d  = pb ? step_down(duty_q) : duty_q;
        end else begin
          state_d = ST_DRIVE;
          duty_d  = pb ? ramp_toward(duty_q, tgt) : duty_q;
        end
      end
      ST_BRAKE: begin
        if (run_db && (dir_db == dir_lat_q) && (duty_q != ZERO_D)) begin
          state_d = ST_DRIVE;
          duty_d  = pb ? ramp_toward(duty_q, tgt) : duty_q;
        end else if (pb) begin
          if (duty_q == ZERO_D) begin
            state_d    = ST_DEAD;
            dead_cnt_d = DEAD_LD;
          end else begin
            state_d = ST_BRAKE;
            duty_d  = step_down(duty_q);
          end
        end else begin
          state_d = ST_BRAKE;
        end
      end
      ST_DEAD: begin
        duty_d = ZERO_D;
        if (pb) begin
          if (dead_cnt_q <= DEAD_ONE) begin
            dead_cnt_d = {XW{1'b0}};
            if (run_db) begin
              dir_lat_d = dir_db;
              state_d   = ST_DRIVE;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            dead_cnt_d = dead_cnt_q - DEAD_ONE;
            state_d    = ST_DEAD;
          end
        end else begin
          state_d = ST_DEAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        duty_d  = ZERO_D;
      end
    endcase
    pwm_d = (cnt_q < duty_q);
    case (state_d)
      ST_DRIVE, ST_BRAKE: dir_out_d = dir_lat_d ? 2'b10 : 2'b01;
      default:            dir_out_d = 2'b00;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 3'b000;
      sync2_q    <= 3'b000;
      db_q       <= 3'b000;
      stab_q     <= {SW{1'b0}};
      cnt_q      <= ZERO_D;
      duty_q     <= ZERO_D;
      dead_cnt_q <= {XW{1'b0}};
      state_q    <= ST_IDLE;
      dir_lat_q  <= 1'b0;
      pwm_q      <= 1'b0;
      dir_out_q  <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_q       <= db_d;
      stab_q     <= stab_d;
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      dead_cnt_q <= dead_cnt_d;
      state_q    <= state_d;
      dir_lat_q  <= dir_lat_d;
      pwm_q      <= pwm_d;
      dir_out_q  <= dir_out_d;
      busy_q     <= busy_d;
    end
  end

  assign motor_r = {pwm_q, dir_out_q};
  assign motor_l = {pwm_q, dir_out_q};
  assign duty    = duty_q;
  assign state   = state_q;
  assign busy    = busy_q;

endmodule
